// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared state, opcode and datapath-select encodings for the multicycle MIPS control
//
// Purpose: one place for the FSM state enum, the opcodes the controller decodes,
// and the mux-select encodings it drives into the datapath.
// Ports: none (package).
package mips_pkg;

   typedef enum logic [3:0] {
      S_FETCH   = 4'd0,
      S_DECODE  = 4'd1,
      S_MEMADR  = 4'd2,
      S_MEMRD   = 4'd3,
      S_MEMWB   = 4'd4,
      S_MEMWR   = 4'd5,
      S_RTYPEEX = 4'd6,
      S_RTYPEWB = 4'd7,
      S_BEQEX   = 4'd8,
      S_ADDIEX  = 4'd9,
      S_ADDIWB  = 4'd10,
      S_JEX     = 4'd11,
      S_JALEX   = 4'd12
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_JAL   = 6'b000011;

   localparam logic [1:0] ALUSRCB_RT    = 2'b00;
   localparam logic [1:0] ALUSRCB_FOUR  = 2'b01;
   localparam logic [1:0] ALUSRCB_IMM   = 2'b10;
   localparam logic [1:0] ALUSRCB_IMMSH = 2'b11;

   localparam logic [1:0] PCSRC_ALU    = 2'b00;
   localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
   localparam logic [1:0] PCSRC_JUMP   = 2'b10;

   localparam logic [1:0] REGDST_RT  = 2'b00;
   localparam logic [1:0] REGDST_RD  = 2'b01;
   localparam logic [1:0] REGDST_R31 = 2'b10;

   localparam logic [1:0] MEMTOREG_ALUOUT = 2'b00;
   localparam logic [1:0] MEMTOREG_MDR    = 2'b01;
   localparam logic [1:0] MEMTOREG_PC     = 2'b10;

   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;

endpackage

// File: rtl/mcycle_nextstate.sv
// rtl/mcycle_nextstate.sv - combinational next-state function of the multicycle control FSM
//
// Purpose: given the current state, the instruction opcode and the memory ready
// handshake, select the next state and flag unsupported opcodes in DECODE.
// Ports:
//   state_i      current FSM state
//   op_i         opcode field of the instruction register
//   mem_ready_i  memory completes the current request this cycle
//   next_o       next FSM state
//   illegal_o    unsupported opcode seen in DECODE (Mealy on op_i)
module mcycle_nextstate
   import mips_pkg::*;
(
   input  state_t     state_i,
   input  logic [5:0] op_i,
   input  logic       mem_ready_i,
   output state_t     next_o,
   output logic       illegal_o
);

   always_comb begin
      next_o    = S_FETCH;
      illegal_o = 1'b0;
      case (state_i)
         S_FETCH:   next_o = mem_ready_i ? S_DECODE : S_FETCH;
         S_DECODE: begin
            case (op_i)
               OP_RTYPE:     next_o = S_RTYPEEX;
               OP_LW, OP_SW: next_o = S_MEMADR;
               OP_BEQ:       next_o = S_BEQEX;
               OP_ADDI:      next_o = S_ADDIEX;
               OP_J:         next_o = S_JEX;
               OP_JAL:       next_o = S_JALEX;
               default: begin
                  next_o    = S_FETCH;
                  illegal_o = 1'b1;
               end
            endcase
         end
         // Only LW and SW reach MEMADR, so anything that is not LW is SW.
         S_MEMADR:  next_o = (op_i == OP_LW) ? S_MEMRD : S_MEMWR;
         S_MEMRD:   next_o = mem_ready_i ? S_MEMWB : S_MEMRD;
         S_MEMWR:   next_o = mem_ready_i ? S_FETCH : S_MEMWR;
         S_RTYPEEX: next_o = S_RTYPEWB;
         S_ADDIEX:  next_o = S_ADDIWB;
         default:   next_o = S_FETCH;
      endcase
   end

endmodule

// File: rtl/mcycle_ctrl.sv
// rtl/mcycle_ctrl.sv - multicycle MIPS control FSM driving ALU, unified memory port and register file
//
// Purpose: sequences FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK, stalling on mem_ready.
// Optional feature macro: MCYCLE_CTRL_PERF_EN adds cycle_cnt and instret counters.
// Ports:
//   clk, reset_n      clock, synchronous active-low reset (forces all outputs to 0)
//   op, mem_ready     opcode from IR, memory completion handshake
//   mem_req, iord, memwrite               memory request, address source, write qualifier
//   irwrite, pcwrite, branch, regwrite    register enables
//   regdst, memtoreg, alusrca, alusrcb, pcsrc, aluop   datapath selects
//   illegal           one-cycle pulse on unsupported opcode
//   state_o           current state for debug
//   cycle_cnt, instret  (MCYCLE_CTRL_PERF_EN only) performance counters, width n
module mcycle_ctrl
   import mips_pkg::*;
`ifdef MCYCLE_CTRL_PERF_EN
#(
   parameter int unsigned n = 32
)
`endif
(
   input  logic       clk,
   input  logic       reset_n,
   input  logic [5:0] op,
   input  logic       mem_ready,
   output logic       mem_req,
   output logic       iord,
   output logic       memwrite,
   output logic       irwrite,
   output logic       pcwrite,
   output logic       branch,
   output logic       regwrite,
   output logic [1:0] regdst,
   output logic [1:0] memtoreg,
   output logic       alusrca,
   output logic [1:0] alusrcb,
   output logic [1:0] pcsrc,
   output logic [1:0] aluop,
   output logic       illegal,
   output logic [3:0] state_o
`ifdef MCYCLE_CTRL_PERF_EN
   ,
   output logic [n-1:0] cycle_cnt,
   output logic [n-1:0] instret
`endif
);

   state_t state_q, state_d;
   logic   illegal_w;

   mcycle_nextstate u_nextstate (
      .state_i     (state_q),
      .op_i        (op),
      .mem_ready_i (mem_ready),
      .next_o      (state_d),
      .illegal_o   (illegal_w)
   );

   always_ff @(posedge clk) begin
      if (!reset_n) state_q <= S_FETCH;
      else          state_q <= state_d;
   end

   // Everything is gated by reset_n so a reset aborts an outstanding request
   // in the very cycle it is asserted, not at the following edge.
   always_comb begin
      mem_req  = 1'b0;
      iord     = 1'b0;
      memwrite = 1'b0;
      irwrite  = 1'b0;
      pcwrite  = 1'b0;
      branch   = 1'b0;
      regwrite = 1'b0;
      regdst   = REGDST_RT;
      memtoreg = MEMTOREG_ALUOUT;
      alusrca  = 1'b0;
      alusrcb  = ALUSRCB_RT;
      pcsrc    = PCSRC_ALU;
      aluop    = ALUOP_ADD;
      illegal  = 1'b0;
      state_o  = 4'd0;
      if (reset_n) begin
         state_o = state_q;
         illegal = illegal_w;
         case (state_q)
            S_FETCH: begin
               mem_req = 1'b1;
               alusrcb = ALUSRCB_FOUR;
               pcsrc   = PCSRC_ALU;
               aluop   = ALUOP_ADD;
               // IR and PC load only when the fetch actually completes.
               irwrite = mem_ready;
               pcwrite = mem_ready;
            end
            S_DECODE: alusrcb = ALUSRCB_IMMSH;
            S_MEMADR: begin
               alusrca = 1'b1;
               alusrcb = ALUSRCB_IMM;
            end
            S_MEMRD: begin
               mem_req = 1'b1;
               iord    = 1'b1;
            end
            S_MEMWB: begin
               regwrite = 1'b1;
               regdst   = REGDST_RT;
               memtoreg = MEMTOREG_MDR;
            end
            S_MEMWR: begin
               mem_req  = 1'b1;
               memwrite = 1'b1;
               iord     = 1'b1;
            end
            S_RTYPEEX: begin
               alusrca = 1'b1;
               alusrcb = ALUSRCB_RT;
               aluop   = ALUOP_FUNCT;
            end
            S_RTYPEWB: begin
               regwrite = 1'b1;
               regdst   = REGDST_RD;
               memtoreg = MEMTOREG_ALUOUT;
            end
            S_BEQEX: begin
               alusrca = 1'b1;
               aluop   = ALUOP_SUB;
               branch  = 1'b1;
               pcsrc   = PCSRC_ALUOUT;
            end
            S_ADDIEX: begin
               alusrca = 1'b1;
               alusrcb = ALUSRCB_IMM;
            end
            S_ADDIWB: regwrite = 1'b1;
            S_JEX: begin
               pcwrite = 1'b1;
               pcsrc   = PCSRC_JUMP;
            end
            S_JALEX: begin
               // r31 takes the PC already advanced during FETCH.
               pcwrite  = 1'b1;
               pcsrc    = PCSRC_JUMP;
               regwrite = 1'b1;
               regdst   = REGDST_R31;
               memtoreg = MEMTOREG_PC;
            end
            default: ;
         endcase
      end
   end

`ifdef MCYCLE_CTRL_PERF_EN
   logic [n-1:0] cycle_cnt_q, instret_q;
   logic         retire;

   // An instruction retires when control returns to FETCH from elsewhere,
   // except the DECODE abort of an unsupported opcode.
   assign retire = (state_q != S_FETCH) && (state_d == S_FETCH) && !illegal_w;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         cycle_cnt_q <= '0;
         instret_q   <= '0;
      end else begin
         cycle_cnt_q <= cycle_cnt_q + {{(n-1){1'b0}}, 1'b1};
         if (retire) instret_q <= instret_q + {{(n-1){1'b0}}, 1'b1};
      end
   end

   assign cycle_cnt = cycle_cnt_q;
   assign instret   = instret_q;
`endif

endmodule

// File: tb/tb_mcycle_ctrl.sv
// tb/tb_mcycle_ctrl.sv - randomized scoreboard bench for the multicycle MIPS control FSM
module tb_mcycle_ctrl;

   typedef struct packed {
      logic       mem_req;
      logic       iord;
      logic       memwrite;
      logic       irwrite;
      logic       pcwrite;
      logic       branch;
      logic       regwrite;
      logic [1:0] regdst;
      logic [1:0] memtoreg;
      logic       alusrca;
      logic [1:0] alusrcb;
      logic [1:0] pcsrc;
      logic [1:0] aluop;
      logic       illegal;
   } out_t;

   typedef struct {
      bit         rst_n;
      logic [5:0] op;
      bit         rdy;
      bit         retire;
      int         st;
      out_t       o;
   } stim_t;

   typedef struct {
      int          st;
      out_t        o;
      bit          chk_cnt;
      logic [31:0] cyc;
      logic [31:0] ret;
   } exp_t;

   logic       clk = 1'b0;
   logic       reset_n;
   logic [5:0] op;
   logic       mem_ready;
   logic       mem_req, iord, memwrite, irwrite, pcwrite, branch, regwrite, alusrca, illegal;
   logic [1:0] regdst, memtoreg, alusrcb, pcsrc, aluop;
   logic [3:0] state_o;
`ifdef MCYCLE_CTRL_PERF_EN
   logic [31:0] cycle_cnt, instret;
`endif

   mcycle_ctrl dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .op        (op),
      .mem_ready (mem_ready),
      .mem_req   (mem_req),
      .iord      (iord),
      .memwrite  (memwrite),
      .irwrite   (irwrite),
      .pcwrite   (pcwrite),
      .branch    (branch),
      .regwrite  (regwrite),
      .regdst    (regdst),
      .memtoreg  (memtoreg),
      .alusrca   (alusrca),
      .alusrcb   (alusrcb),
      .pcsrc     (pcsrc),
      .aluop     (aluop),
      .illegal   (illegal),
      .state_o   (state_o)
`ifdef MCYCLE_CTRL_PERF_EN
      ,
      .cycle_cnt (cycle_cnt),
      .instret   (instret)
`endif
   );

   always #5 clk = ~clk;

   stim_t stim_q[$];
   exp_t  sb_q[$];
   int    n_checks = 0;
   int    n_fail   = 0;
   int    cyc_idx  = 0;

   out_t act;
   assign act = {mem_req, iord, memwrite, irwrite, pcwrite, branch, regwrite,
                 regdst, memtoreg, alusrca, alusrcb, pcsrc, aluop, illegal};

   function automatic bit is_legal(logic [5:0] o);
      return o == 6'b000000 || o == 6'b100011 || o == 6'b101011 || o == 6'b000100 ||
             o == 6'b001000 || o == 6'b000010 || o == 6'b000011;
   endfunction

   task automatic add(int st, bit rdy, logic [5:0] o_op, out_t o, bit ret);
      stim_t s;
      s.rst_n = 1'b1; s.op = o_op; s.rdy = rdy; s.retire = ret; s.st = st; s.o = o;
      stim_q.push_back(s);
   endtask

   task automatic add_reset(bit rdy);
      stim_t s;
      s.rst_n = 1'b0; s.op = 6'($urandom); s.rdy = rdy; s.retire = 1'b0; s.st = 0; s.o = '0;
      stim_q.push_back(s);
   endtask

   // Reference model: expands one instruction into its per-cycle expected control word.
   // fw = FETCH wait cycles, mw = data memory wait cycles.
   task automatic gen_instr(logic [5:0] iop, int fw, int mw);
      out_t o;
      for (int i = 0; i < fw; i++) begin
         o = '0; o.mem_req = 1; o.alusrcb = 2'b01;
         add(0, 1'b0, 6'($urandom), o, 1'b0);
      end
      o = '0; o.mem_req = 1; o.alusrcb = 2'b01; o.irwrite = 1; o.pcwrite = 1;
      add(0, 1'b1, 6'($urandom), o, 1'b0);
      o = '0; o.alusrcb = 2'b11; o.illegal = !is_legal(iop);
      add(1, 1'($urandom), iop, o, 1'b0);
      if (!is_legal(iop)) return;
      case (iop)
         6'b000000: begin
            o = '0; o.alusrca = 1; o.aluop = 2'b10;
            add(6, 1'($urandom), iop, o, 1'b0);
            o = '0; o.regwrite = 1; o.regdst = 2'b01;
            add(7, 1'($urandom), iop, o, 1'b1);
         end
         6'b100011, 6'b101011: begin
            o = '0; o.alusrca = 1; o.alusrcb = 2'b10;
            add(2, 1'($urandom), iop, o, 1'b0);
            o = '0; o.mem_req = 1; o.iord = 1; o.memwrite = (iop == 6'b101011);
            for (int i = 0; i < mw; i++) add(iop == 6'b100011 ? 3 : 5, 1'b0, iop, o, 1'b0);
            add(iop == 6'b100011 ? 3 : 5, 1'b1, iop, o, iop == 6'b101011);
            if (iop == 6'b100011) begin
               o = '0; o.regwrite = 1; o.memtoreg = 2'b01;
               add(4, 1'($urandom), iop, o, 1'b1);
            end
         end
         6'b000100: begin
            o = '0; o.alusrca = 1; o.aluop = 2'b01; o.branch = 1; o.pcsrc = 2'b01;
            add(8, 1'($urandom), iop, o, 1'b1);
         end
         6'b001000: begin
            o = '0; o.alusrca = 1; o.alusrcb = 2'b10;
            add(9, 1'($urandom), iop, o, 1'b0);
            o = '0; o.regwrite = 1;
            add(10, 1'($urandom), iop, o, 1'b1);
         end
         6'b000010: begin
            o = '0; o.pcwrite = 1; o.pcsrc = 2'b10;
            add(11, 1'($urandom), iop, o, 1'b1);
         end
         default: begin
            o = '0; o.pcwrite = 1; o.pcsrc = 2'b10; o.regwrite = 1;
            o.regdst = 2'b10; o.memtoreg = 2'b10;
            add(12, 1'($urandom), iop, o, 1'b1);
         end
      endcase
   endtask

   task automatic check(string name, logic [31:0] got, logic [31:0] want);
      n_checks++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s at cycle %0d: got %0h want %0h", name, cyc_idx, got, want);
      end
   endtask

   // Monitor: compares DUT outputs against the oldest expected entry each cycle.
   always @(negedge clk) begin
      if (sb_q.size() > 0) begin
         exp_t e;
         e = sb_q.pop_front();
         check("state", 32'(state_o), 32'(e.st));
         check("ctrl", 32'(act), 32'(e.o));
`ifdef MCYCLE_CTRL_PERF_EN
         if (e.chk_cnt) begin
            check("cycle_cnt", cycle_cnt, e.cyc);
            check("instret", instret, e.ret);
         end
`endif
         cyc_idx++;
      end
   end

   initial begin
      logic [5:0]  lops [7];
      logic [5:0]  rop;
      logic [31:0] cyc, ret;
      int          keep;
      stim_t       s;
      exp_t        e;

      lops[0] = 6'b000000; lops[1] = 6'b100011; lops[2] = 6'b101011; lops[3] = 6'b000100;
      lops[4] = 6'b001000; lops[5] = 6'b000010; lops[6] = 6'b000011;

      reset_n = 1'b0; op = '0; mem_ready = 1'b0;

      add_reset(1'b1); add_reset(1'b1);
      gen_instr(6'b000000, 0, 0);
      gen_instr(6'b100011, 0, 2);
      gen_instr(6'b101011, 3, 0);
      gen_instr(6'b000100, 0, 0);
      gen_instr(6'b000011, 0, 0);
      gen_instr(6'b111111, 0, 0);
      gen_instr(6'b000010, 1, 0);
      gen_instr(6'b001000, 0, 0);
      // Reset while MEMWR is waiting on the memory.
      gen_instr(6'b101011, 0, 3);
      repeat (2) void'(stim_q.pop_back());
      add_reset(1'b0);
      gen_instr(6'b000000, 0, 0);
      gen_instr(6'b100011, 0, 0);
      gen_instr(6'b110011, 0, 0);
      for (int i = 0; i < 80; i++) begin
         if ($urandom_range(0, 7) == 0) rop = 6'($urandom);
         else rop = lops[$urandom_range(0, 6)];
         gen_instr(rop, $urandom_range(0, 3), $urandom_range(0, 3));
         if ($urandom_range(0, 15) == 0) begin
            keep = $urandom_range(1, 3);
            while (keep > 0 && stim_q.size() > 1) begin
               void'(stim_q.pop_back());
               keep--;
            end
            add_reset(1'($urandom));
         end
      end

      cyc = 0; ret = 0;
      while (stim_q.size() > 0) begin
         s = stim_q.pop_front();
         @(posedge clk);
         #1;
         reset_n = s.rst_n; op = s.op; mem_ready = s.rdy;
         e.st = s.st; e.o = s.o; e.chk_cnt = s.rst_n; e.cyc = cyc; e.ret = ret;
         sb_q.push_back(e);
         if (!s.rst_n) begin
            cyc = 0; ret = 0;
         end else begin
            cyc++;
            if (s.retire) ret++;
         end
      end
      @(posedge clk);
      @(posedge clk);
      check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #400000;
      n_checks++;
      n_fail++;
      $display("FAIL timeout: got %0d pending entries want 0", sb_q.size());
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
